// File: rtl/svutest_req_rsp_sender.sv
// rtl/svutest_req_rsp_sender.sv - queued req/rsp sender with outstanding limit and response timeout
//
// Test-case code pushes payloads into a FIFO. Each payload is issued as a one-cycle
// registered req pulse, at most MAX_OUTSTANDING requests await rsp, and stalled
// responses (timeout) or responses nobody asked for (unexpected_rsp) raise sticky flags.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_payload  enqueue strobe and data; push_ready is FIFO-not-full
//   req, req_payload    registered request pulse and its payload
//   rsp                 response pulse, one per request
//   clear               clears sticky flags and the timer
//   queued, outstanding FIFO occupancy, requests awaiting rsp
//   rsp_count           accepted responses (wraps)
//   timeout             sticky response timeout
//   unexpected_rsp      sticky rsp with nothing outstanding
//   idle                nothing queued, nothing outstanding, no req
module svutest_req_rsp_sender #(
    parameter int W_PAYLOAD       = 32,
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic [W_PAYLOAD-1:0]               push_payload,
    output logic                               push_ready,
    output logic                               req,
    output logic [W_PAYLOAD-1:0]               req_payload,
    input  logic                               rsp,
    input  logic                               clear,
    output logic [$clog2(DEPTH+1)-1:0]         queued,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic [31:0]                        rsp_count,
    output logic                               timeout,
    output logic                               unexpected_rsp,
    output logic                               idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int QW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [QW-1:0] DEPTH_Q   = QW'(DEPTH);
    localparam logic [OW-1:0] MAX_OUT_O = OW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

    logic [W_PAYLOAD-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [TW-1:0]        timer;
    logic [TW-1:0]        timer_next;

    logic push_ok;
    logic issue;
    logic rsp_ok;
    logic timeout_hit;

    // Fullness comes from registered occupancy only, so a same-edge pop never
    // lets a full FIFO take a push.
    assign push_ready = !rst && (queued != DEPTH_Q);
    assign push_ok    = push && push_ready;
    assign issue      = (queued != '0) && (outstanding < MAX_OUT_O) && !timeout;
    assign rsp_ok     = rsp && (outstanding != '0);
    assign idle       = (queued == '0) && (outstanding == '0) && !req;

    always_comb begin
        timer_next = timer;
        if (TIMEOUT == 0 || clear || outstanding == '0 || rsp_ok) begin
            timer_next = '0;
        end else if (timer != TIMEOUT_T) begin
            timer_next = timer + TW'(1);
        end
    end

    // Raised on the edge where the timer arrives at TIMEOUT; clear wins.
    assign timeout_hit = (TIMEOUT > 0) && !clear && (timer_next == TIMEOUT_T);

    // Storage carries no reset: emptiness is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_payload;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            queued         <= '0;
            outstanding    <= '0;
            req            <= 1'b0;
            req_payload    <= '0;
            rsp_count      <= '0;
            timer          <= '0;
            timeout        <= 1'b0;
            unexpected_rsp <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end

            req <= issue;
            if (issue) begin
                req_payload <= mem[rd_ptr];
                rd_ptr      <= rd_ptr + PW'(1);
            end

            case ({push_ok, issue})
                2'b10:   queued <= queued + QW'(1);
                2'b01:   queued <= queued - QW'(1);
                default: queued <= queued;
            endcase

            case ({issue, rsp_ok})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase

            if (rsp_ok) begin
                rsp_count <= rsp_count + 32'd1;
            end

            timer <= timer_next;

            if (clear) begin
                timeout <= 1'b0;
            end else if (timeout_hit) begin
                timeout <= 1'b1;
            end

            if (clear) begin
                unexpected_rsp <= 1'b0;
            end else if (rsp && outstanding == '0) begin
                unexpected_rsp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_svutest_req_rsp_sender.sv
// tb/tb_svutest_req_rsp_sender.sv - directed self-checking bench for svutest_req_rsp_sender
module tb_svutest_req_rsp_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0;
    logic [31:0] push_payload = '0;
    logic        push_ready;
    logic        req;
    logic [31:0] req_payload;
    logic        rsp = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  queued;
    logic [2:0]  outstanding;
    logic [31:0] rsp_count;
    logic        timeout;
    logic        unexpected_rsp;
    logic        idle;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] seen[$];

    svutest_req_rsp_sender #(
        .W_PAYLOAD(32), .DEPTH(8), .MAX_OUTSTANDING(4), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .push(push), .push_payload(push_payload),
        .push_ready(push_ready), .req(req), .req_payload(req_payload),
        .rsp(rsp), .clear(clear), .queued(queued), .outstanding(outstanding),
        .rsp_count(rsp_count), .timeout(timeout), .unexpected_rsp(unexpected_rsp),
        .idle(idle)
    );

    always #5 clk = ~clk;

    // Records every issued request, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (req) seen.push_back(req_payload);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; push = 1'b0; rsp = 1'b0; clear = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen.delete();
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_req", req, 0);
        check("rst_push_ready", push_ready, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_queued", queued, 0);
        check("rst_rsp_count", rsp_count, 0);
        check("rst_flags", {timeout, unexpected_rsp}, 0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rel_push_ready", push_ready, 1);
        check("rel_idle", idle, 1);
        tick();

        // Basic order and latency
        seen.delete();
        push = 1'b1; push_payload = 32'hA1;
        tick();
        check("t1_no_req_yet", req, 0);
        push_payload = 32'hB2;
        tick();
        check("t1_req_first", req, 1);
        check("t1_payload_a1", req_payload, 32'hA1);
        push_payload = 32'hC3;
        tick();
        push = 1'b0;
        check("t1_payload_b2", req_payload, 32'hB2);
        tick();
        rsp = 1'b1;
        repeat (3) tick();
        rsp = 1'b0;
        repeat (3) tick();
        check("t1_rsp_count", rsp_count, 3);
        check("t1_idle", idle, 1);
        check("t1_nreq", seen.size(), 3);
        if (seen.size() == 3) begin
            check("t1_ord0", seen[0], 32'hA1);
            check("t1_ord1", seen[1], 32'hB2);
            check("t1_ord2", seen[2], 32'hC3);
        end

        // Backpressure on outstanding limit
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push = 1'b1; push_payload = 32'h30 + i;
            tick();
        end
        push = 1'b0;
        repeat (6) tick();
        check("t2_nreq", seen.size(), 4);
        check("t2_outstanding", outstanding, 4);
        check("t2_queued", queued, 2);
        rsp = 1'b1;
        tick();
        rsp = 1'b0;
        check("t2_out_after_rsp", outstanding, 3);
        check("t2_no_req_same_edge", req, 0);
        tick();
        check("t2_fifth_req", req, 1);
        check("t2_fifth_payload", req_payload, 32'h34);
        check("t2_out_back4", outstanding, 4);

        // FIFO full with outstanding saturated
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_payload = 32'h10 + i;
            tick();
        end
        push = 1'b0;
        repeat (5) tick();
        check("t3_out_sat", outstanding, 4);
        for (int i = 0; i < 10; i++) begin
            if (i == 8) check("t3_ready_low", push_ready, 0);
            push = 1'b1; push_payload = 32'h20 + i;
            tick();
        end
        push = 1'b0;
        check("t3_queued_full", queued, 8);
        rsp = 1'b1;
        repeat (20) tick();
        rsp = 1'b0;
        tick();
        check("t3_nreq", seen.size(), 12);
        check("t3_rsp_count", rsp_count, 12);
        if (seen.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                check($sformatf("t3_ord%0d", i), seen[i],
                      (i < 4) ? 32'h10 + i : 32'h20 + (i - 4));
            end
        end

        // Timeout
        do_reset();
        push = 1'b1; push_payload = 32'h55;
        tick();
        push = 1'b0;
        tick();
        check("t4_req", req, 1);
        check("t4_out1", outstanding, 1);
        repeat (63) tick();
        check("t4_not_yet", timeout, 0);
        tick();
        check("t4_timeout", timeout, 1);
        push = 1'b1; push_payload = 32'h56;
        tick();
        push_payload = 32'h57;
        tick();
        push = 1'b0;
        repeat (4) tick();
        check("t4_halt_queued", queued, 2);
        check("t4_halt_out", outstanding, 1);
        check("t4_halt_nreq", seen.size(), 1);
        rsp = 1'b1;
        tick();
        rsp = 1'b0;
        check("t4_late_out", outstanding, 0);
        check("t4_late_count", rsp_count, 1);
        check("t4_sticky", timeout, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_cleared", timeout, 0);
        check("t4_no_req_clear_edge", req, 0);
        tick();
        check("t4_resume_req", req, 1);
        check("t4_resume_payload", req_payload, 32'h56);

        // Unexpected response and issue+rsp cancellation
        do_reset();
        rsp = 1'b1;
        tick();
        rsp = 1'b0;
        check("t5_unexp", unexpected_rsp, 1);
        check("t5_count0", rsp_count, 0);
        check("t5_out0", outstanding, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_unexp_clr", unexpected_rsp, 0);
        push = 1'b1; push_payload = 32'h77;
        tick();
        push = 1'b0;
        tick();
        check("t5_out1", outstanding, 1);
        push = 1'b1; push_payload = 32'h78;
        tick();
        push = 1'b0; rsp = 1'b1;
        tick();
        rsp = 1'b0;
        check("t5_cancel_out", outstanding, 1);
        check("t5_cancel_req", req, 1);
        check("t5_cancel_count", rsp_count, 1);

        // Asynchronous reset with queued=3, outstanding=2
        do_reset();
        push = 1'b1; push_payload = 32'h60;
        tick();
        push_payload = 32'h61;
        tick();
        push = 1'b0;
        tick();
        check("t6_out2", outstanding, 2);
        repeat (70) tick();
        check("t6_timeout", timeout, 1);
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_payload = 32'h62 + i;
            tick();
        end
        push = 1'b0;
        tick();
        check("t6_queued3", queued, 3);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_req", req, 0);
        check("t6_async_queued", queued, 0);
        check("t6_async_out", outstanding, 0);
        check("t6_async_ready", push_ready, 0);
        check("t6_async_timeout", timeout, 0);
        tick();
        seen.delete();
        rst = 1'b0;
        repeat (5) tick();
        check("t6_no_req_after", seen.size(), 0);
        check("t6_idle", idle, 1);
        check("t6_ready", push_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
